// File: rtl/axis_frame_err_checker.sv
// Lockstep DUT-vs-reference AXI-Stream frame checker: per-frame SSE, out-of-tolerance count and framing errors.
// Optional worst-sample reporting (res_max_err / res_max_idx) is enabled by defining CHK_MAX_ERR_EN.
module axis_frame_err_checker #(
    parameter int SMP_WDT   = 16,
    parameter int CH_CNT    = 2,
    parameter int FRM_BEATS = 512,
    parameter int TOL_SQ    = 4,
    parameter int ACC_WDT   = 48
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic [CH_CNT*2*SMP_WDT-1:0]            s_axis_dut_tdata,
    input  logic                                   s_axis_dut_tvalid,
    input  logic                                   s_axis_dut_tlast,
    output logic                                   s_axis_dut_tready,
    input  logic [CH_CNT*2*SMP_WDT-1:0]            s_axis_ref_tdata,
    input  logic                                   s_axis_ref_tvalid,
    input  logic                                   s_axis_ref_tlast,
    output logic                                   s_axis_ref_tready,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [ACC_WDT-1:0]                     res_sse,
    output logic [$clog2(FRM_BEATS*CH_CNT+1)-1:0]  res_err_cnt,
    output logic                                   res_len_err,
    output logic                                   res_sat,
`ifdef CHK_MAX_ERR_EN
    output logic [2*SMP_WDT+2:0]                   res_max_err,
    output logic [$clog2(FRM_BEATS*CH_CNT)-1:0]    res_max_idx,
`endif
    output logic [31:0]                            frm_cnt
);
    localparam int DIFF_W = SMP_WDT + 1;
    localparam int EN_W   = 2 * SMP_WDT + 3;
    localparam int ESUM_W = EN_W + $clog2(CH_CNT);
    localparam int ADD_W  = ((ACC_WDT > ESUM_W) ? ACC_WDT : ESUM_W) + 1;
    localparam int CNT_W  = $clog2(FRM_BEATS * CH_CNT + 1);
    localparam int FLG_W  = $clog2(CH_CNT + 1);
    localparam int BEAT_W = (FRM_BEATS > 1) ? $clog2(FRM_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    state_t                   state_reg, state_next;
    logic                     drain_cnt_reg;
    logic [BEAT_W-1:0]        beat_reg;
    logic                     s1_vld_reg, s2_vld_reg;
    logic                     len_err_reg, sat_reg;
    logic [ACC_WDT-1:0]       sse_reg;
    logic [CNT_W-1:0]         err_cnt_reg;
    logic [31:0]              frm_cnt_reg;
    logic                     hs, last_beat, accept;
    logic [CH_CNT-1:0][EN_W-1:0] energy_vec;
    logic [ESUM_W-1:0]        esum;
    logic [FLG_W-1:0]         flag_cnt;
    logic [ADD_W-1:0]         add_wide;
    logic                     add_ovf;

    assign hs        = s_axis_dut_tready;
    assign last_beat = (beat_reg == BEAT_W'(FRM_BEATS - 1));
    assign accept    = res_valid & res_ready;

    always_comb begin
        state_next        = state_reg;
        s_axis_dut_tready = 1'b0;
        s_axis_ref_tready = 1'b0;
        res_valid         = 1'b0;
        case (state_reg)
            IDLE: if (en) state_next = RUN;
            RUN: begin
                // Both streams move together or not at all.
                s_axis_dut_tready = s_axis_dut_tvalid & s_axis_ref_tvalid;
                s_axis_ref_tready = s_axis_dut_tvalid & s_axis_ref_tvalid;
                if (s_axis_dut_tvalid && s_axis_ref_tvalid && last_beat) state_next = DRAIN;
            end
            DRAIN: if (drain_cnt_reg) state_next = REPORT;
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = en ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 1'b0;
            beat_reg      <= '0;
            s1_vld_reg    <= 1'b0;
            s2_vld_reg    <= 1'b0;
            len_err_reg   <= 1'b0;
            frm_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= (state_reg == DRAIN) ? ~drain_cnt_reg : 1'b0;
            s1_vld_reg    <= hs;
            s2_vld_reg    <= s1_vld_reg;
            if (hs) begin
                // The frame length is fixed; tlast is only checked, never obeyed.
                beat_reg <= last_beat ? '0 : beat_reg + BEAT_W'(1);
                if ((s_axis_dut_tlast != last_beat) || (s_axis_ref_tlast != last_beat))
                    len_err_reg <= 1'b1;
            end
            if (accept) begin
                frm_cnt_reg <= frm_cnt_reg + 32'd1;
                len_err_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < CH_CNT; gi++) begin : g_lane
        logic [SMP_WDT-1:0]          d_re, d_im, r_re, r_im;
        logic [DIFF_W-1:0]           diff_re_reg, diff_im_reg;
        logic signed [2*DIFF_W-1:0]  ex_re, ex_im;
        logic [2*DIFF_W-1:0]         sq_re, sq_im;
        logic [EN_W-1:0]             energy_reg;

        assign d_re = s_axis_dut_tdata[gi*2*SMP_WDT+SMP_WDT +: SMP_WDT];
        assign d_im = s_axis_dut_tdata[gi*2*SMP_WDT +: SMP_WDT];
        assign r_re = s_axis_ref_tdata[gi*2*SMP_WDT+SMP_WDT +: SMP_WDT];
        assign r_im = s_axis_ref_tdata[gi*2*SMP_WDT +: SMP_WDT];

        assign ex_re = {{DIFF_W{diff_re_reg[DIFF_W-1]}}, diff_re_reg};
        assign ex_im = {{DIFF_W{diff_im_reg[DIFF_W-1]}}, diff_im_reg};
        assign sq_re = ex_re * ex_re;
        assign sq_im = ex_im * ex_im;

        always_ff @(posedge clk) begin
            if (hs) begin
                diff_re_reg <= {d_re[SMP_WDT-1], d_re} - {r_re[SMP_WDT-1], r_re};
                diff_im_reg <= {d_im[SMP_WDT-1], d_im} - {r_im[SMP_WDT-1], r_im};
            end
            if (s1_vld_reg)
                energy_reg <= EN_W'(sq_re) + EN_W'(sq_im);
        end

        assign energy_vec[gi] = energy_reg;
    end

    always_comb begin
        esum     = '0;
        flag_cnt = '0;
        for (int k = 0; k < CH_CNT; k++) begin
            esum     = esum + ESUM_W'(energy_vec[k]);
            flag_cnt = flag_cnt + FLG_W'(energy_vec[k] > EN_W'(TOL_SQ));
        end
    end

    // One spare bit above the accumulator catches any carry out for saturation.
    assign add_wide = ADD_W'(sse_reg) + ADD_W'(esum);
    assign add_ovf  = |add_wide[ADD_W-1:ACC_WDT];

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            sse_reg     <= '0;
            sat_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else if (s2_vld_reg) begin
            if (add_ovf) begin
                sse_reg <= '1;
                sat_reg <= 1'b1;
            end else begin
                sse_reg <= add_wide[ACC_WDT-1:0];
            end
            err_cnt_reg <= err_cnt_reg + CNT_W'(flag_cnt);
        end
    end

    assign res_sse     = sse_reg;
    assign res_err_cnt = err_cnt_reg;
    assign res_len_err = len_err_reg;
    assign res_sat     = sat_reg;
    assign frm_cnt     = frm_cnt_reg;

`ifdef CHK_MAX_ERR_EN
    localparam int IDX_W  = $clog2(FRM_BEATS * CH_CNT);
    localparam int LANE_W = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;

    logic [BEAT_W-1:0] s1_beat_reg, s2_beat_reg;
    logic [EN_W-1:0]   best_e, max_err_reg;
    logic [LANE_W-1:0] best_lane;
    logic [IDX_W-1:0]  max_idx_reg;

    // Strict comparisons keep the lowest flat index on ties.
    always_comb begin
        best_e    = energy_vec[0];
        best_lane = '0;
        for (int k = 1; k < CH_CNT; k++) begin
            if (energy_vec[k] > best_e) begin
                best_e    = energy_vec[k];
                best_lane = LANE_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs)         s1_beat_reg <= beat_reg;
        if (s1_vld_reg) s2_beat_reg <= s1_beat_reg;
        if (rst || accept) begin
            max_err_reg <= '0;
            max_idx_reg <= '0;
        end else if (s2_vld_reg && (best_e > max_err_reg)) begin
            max_err_reg <= best_e;
            max_idx_reg <= IDX_W'(s2_beat_reg) * IDX_W'(CH_CNT) + IDX_W'(best_lane);
        end
    end

    assign res_max_err = max_err_reg;
    assign res_max_idx = max_idx_reg;
`endif
endmodule

// File: tb/tb_axis_frame_err_checker.sv
// Directed, table-driven bench for axis_frame_err_checker (FRM_BEATS=4), with a second ACC_WDT=34 instance for saturation.
`timescale 1ns/1ps
module tb_axis_frame_err_checker;
    localparam int SMP_WDT = 16, CH_CNT = 2, FRM_BEATS = 4, TOL_SQ = 4;
    localparam int ACC_WDT = 48, ACC_WDT_S = 34;
    localparam int DW    = CH_CNT * 2 * SMP_WDT;
    localparam int CNT_W = $clog2(FRM_BEATS * CH_CNT + 1);
    localparam int IDX_W = $clog2(FRM_BEATS * CH_CNT);
    localparam int EN_W  = 2 * SMP_WDT + 3;

    logic clk = 1'b0;
    logic rst, en, res_ready;
    logic [DW-1:0] dut_tdata, ref_tdata;
    logic dut_tvalid, dut_tlast, ref_tvalid, ref_tlast;
    logic dut_tready, ref_tready, res_valid, res_len_err, res_sat;
    logic [ACC_WDT-1:0] res_sse;
    logic [CNT_W-1:0] res_err_cnt;
    logic [31:0] frm_cnt;
    logic s_dut_tready, s_ref_tready, s_res_valid, s_len_err, s_sat;
    logic [ACC_WDT_S-1:0] s_sse;
    logic [CNT_W-1:0] s_err_cnt;
    logic [31:0] s_frm_cnt;
`ifdef CHK_MAX_ERR_EN
    logic [EN_W-1:0] res_max_err, s_max_err;
    logic [IDX_W-1:0] res_max_idx, s_max_idx;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int exp_frm = 0;

    always #5 clk = ~clk;

    axis_frame_err_checker #(.SMP_WDT(SMP_WDT), .CH_CNT(CH_CNT), .FRM_BEATS(FRM_BEATS),
                             .TOL_SQ(TOL_SQ), .ACC_WDT(ACC_WDT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_axis_dut_tdata(dut_tdata), .s_axis_dut_tvalid(dut_tvalid),
        .s_axis_dut_tlast(dut_tlast), .s_axis_dut_tready(dut_tready),
        .s_axis_ref_tdata(ref_tdata), .s_axis_ref_tvalid(ref_tvalid),
        .s_axis_ref_tlast(ref_tlast), .s_axis_ref_tready(ref_tready),
        .res_valid(res_valid), .res_ready(res_ready), .res_sse(res_sse),
        .res_err_cnt(res_err_cnt), .res_len_err(res_len_err), .res_sat(res_sat),
`ifdef CHK_MAX_ERR_EN
        .res_max_err(res_max_err), .res_max_idx(res_max_idx),
`endif
        .frm_cnt(frm_cnt)
    );

    axis_frame_err_checker #(.SMP_WDT(SMP_WDT), .CH_CNT(CH_CNT), .FRM_BEATS(FRM_BEATS),
                             .TOL_SQ(TOL_SQ), .ACC_WDT(ACC_WDT_S)) dut_s (
        .clk(clk), .rst(rst), .en(en),
        .s_axis_dut_tdata(dut_tdata), .s_axis_dut_tvalid(dut_tvalid),
        .s_axis_dut_tlast(dut_tlast), .s_axis_dut_tready(s_dut_tready),
        .s_axis_ref_tdata(ref_tdata), .s_axis_ref_tvalid(ref_tvalid),
        .s_axis_ref_tlast(ref_tlast), .s_axis_ref_tready(s_ref_tready),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_sse(s_sse),
        .res_err_cnt(s_err_cnt), .res_len_err(s_len_err), .res_sat(s_sat),
`ifdef CHK_MAX_ERR_EN
        .res_max_err(s_max_err), .res_max_idx(s_max_idx),
`endif
        .frm_cnt(s_frm_cnt)
    );

    typedef struct {
        int a_beat, a_lane, a_dre, a_dim, a_rre, a_rim;
        int b_beat, b_lane, b_dre, b_dim, b_rre, b_rim;
        bit all_max;
        int dut_last, ref_last;
        longint exp_sse, exp_sse_s, exp_max;
        int exp_cnt, exp_idx;
        bit exp_len, exp_sat, exp_sat_s;
    } rec_t;

    rec_t tv[7];

    function automatic rec_t blank();
        rec_t r;
        r.a_beat = -1; r.a_lane = 0; r.a_dre = 0; r.a_dim = 0; r.a_rre = 0; r.a_rim = 0;
        r.b_beat = -1; r.b_lane = 0; r.b_dre = 0; r.b_dim = 0; r.b_rre = 0; r.b_rim = 0;
        r.all_max = 1'b0; r.dut_last = FRM_BEATS - 1; r.ref_last = FRM_BEATS - 1;
        r.exp_sse = 0; r.exp_sse_s = 0; r.exp_max = 0; r.exp_cnt = 0; r.exp_idx = 0;
        r.exp_len = 1'b0; r.exp_sat = 1'b0; r.exp_sat_s = 1'b0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic beat_data(input rec_t r, input int b, output logic [DW-1:0] d, output logic [DW-1:0] q);
        for (int l = 0; l < CH_CNT; l++) begin
            int rre, rim, dre, dim;
            rre = b * 100 + l * 10 + 1;
            rim = -(b * 7 + l * 3);
            dre = rre;
            dim = rim;
            if (r.all_max) begin
                dre = 32767; dim = 32767; rre = -32768; rim = -32768;
            end
            if (b == r.a_beat && l == r.a_lane) begin
                dre = r.a_dre; dim = r.a_dim; rre = r.a_rre; rim = r.a_rim;
            end
            if (b == r.b_beat && l == r.b_lane) begin
                dre = r.b_dre; dim = r.b_dim; rre = r.b_rre; rim = r.b_rim;
            end
            d[l*2*SMP_WDT +: 2*SMP_WDT] = {SMP_WDT'(dre), SMP_WDT'(dim)};
            q[l*2*SMP_WDT +: 2*SMP_WDT] = {SMP_WDT'(rre), SMP_WDT'(rim)};
        end
    endtask

    // Runs one frame; optional ref stall before stall_beat, res_ready hold, or abort after abort_after beats.
    task automatic run_frame(input rec_t r, input int stall_beat, input int hold, input int abort_after, input string tag);
        logic [DW-1:0] d, q;
        int b, n;
        bit stalled;
        b = 0; n = 0; stalled = 1'b0;
        en = 1'b1;
        while (b < FRM_BEATS) begin
            beat_data(r, b, d, q);
            dut_tdata = d; ref_tdata = q;
            dut_tlast = (b == r.dut_last); ref_tlast = (b == r.ref_last);
            dut_tvalid = 1'b1; ref_tvalid = 1'b1;
            if (b == stall_beat && !stalled) begin
                stalled = 1'b1;
                ref_tvalid = 1'b0;
                repeat (5) begin
                    #1;
                    chk({tag, "_stall_tready"}, {62'd0, dut_tready, ref_tready}, 64'd0);
                    @(posedge clk); #1;
                end
                ref_tvalid = 1'b1;
            end
            #1;
            if (dut_tready && ref_tready) begin
                @(posedge clk); #1;
                b++;
                en = 1'b0;
                if (b == abort_after) begin
                    dut_tvalid = 1'b0; ref_tvalid = 1'b0;
                    return;
                end
            end else begin
                @(posedge clk); #1;
                n++;
                if (n > 50) begin
                    chk({tag, "_handshake_timeout"}, 64'd0, 64'd1);
                    dut_tvalid = 1'b0; ref_tvalid = 1'b0;
                    return;
                end
            end
        end
        dut_tvalid = 1'b0; ref_tvalid = 1'b0; dut_tlast = 1'b0; ref_tlast = 1'b0;
        n = 1;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd3);
        chk({tag, "_sse"}, 64'(res_sse), 64'(r.exp_sse));
        chk({tag, "_err_cnt"}, 64'(res_err_cnt), 64'(r.exp_cnt));
        chk({tag, "_len_err"}, 64'(res_len_err), 64'(r.exp_len));
        chk({tag, "_sat"}, 64'(res_sat), 64'(r.exp_sat));
        chk({tag, "_sse34"}, 64'(s_sse), 64'(r.exp_sse_s));
        chk({tag, "_sat34"}, 64'(s_sat), 64'(r.exp_sat_s));
        chk({tag, "_frm_cnt_before"}, 64'(frm_cnt), 64'(exp_frm));
`ifdef CHK_MAX_ERR_EN
        chk({tag, "_max_err"}, 64'(res_max_err), 64'(r.exp_max));
        chk({tag, "_max_idx"}, 64'(res_max_idx), 64'(r.exp_idx));
`endif
        if (hold > 0) begin
            dut_tvalid = 1'b1; ref_tvalid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_tready"}, {62'd0, dut_tready, ref_tready}, 64'd0);
                chk({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
                chk({tag, "_hold_sse"}, 64'(res_sse), 64'(r.exp_sse));
                chk({tag, "_hold_err_cnt"}, 64'(res_err_cnt), 64'(r.exp_cnt));
            end
            dut_tvalid = 1'b0; ref_tvalid = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_frm++;
        chk({tag, "_frm_cnt_after"}, 64'(frm_cnt), 64'(exp_frm));
        chk({tag, "_valid_after"}, 64'(res_valid), 64'd0);
        chk({tag, "_sse_cleared"}, 64'(res_sse), 64'd0);
        $display("frame %s: sse=%0d err_cnt=%0d len_err=%0d sat=%0d sse34=%0d sat34=%0d frm_cnt=%0d",
                 tag, r.exp_sse, r.exp_cnt, r.exp_len, r.exp_sat, r.exp_sse_s, r.exp_sat_s, frm_cnt);
    endtask

    initial begin
        rec_t r;
        r = blank(); tv[0] = r;
        r = blank();
        r.a_beat = 1; r.a_lane = 0; r.a_dre = 103; r.a_dim = -2; r.a_rre = 100; r.a_rim = 0;
        r.exp_sse = 13; r.exp_sse_s = 13; r.exp_cnt = 1; r.exp_max = 13; r.exp_idx = 2;
        tv[1] = r;
        r = blank(); r.dut_last = 2; r.exp_len = 1'b1; tv[2] = r;
        r = blank(); tv[3] = r;
        r = blank(); r.all_max = 1'b1;
        r.exp_sse = 64'd68717379600; r.exp_sse_s = 64'd17179869183; r.exp_sat_s = 1'b1;
        r.exp_cnt = 8; r.exp_max = 64'd8589672450; r.exp_idx = 0;
        tv[4] = r;
        r = blank();
        r.a_beat = 0; r.a_lane = 1; r.a_dre = 12; r.a_dim = 5; r.a_rre = 10; r.a_rim = 5;
        r.b_beat = 3; r.b_lane = 1; r.b_dre = -3; r.b_dim = 7; r.b_rre = -5; r.b_rim = 6;
        r.exp_sse = 9; r.exp_sse_s = 9; r.exp_cnt = 1; r.exp_max = 5; r.exp_idx = 7;
        tv[5] = r;
        r = blank();
        r.a_beat = 2; r.a_lane = 1; r.a_dre = -1000; r.a_dim = 0; r.a_rre = 1000; r.a_rim = 0;
        r.b_beat = 0; r.b_lane = 0; r.b_dre = 5; r.b_dim = -3; r.b_rre = 5; r.b_rim = 0;
        r.exp_sse = 4000009; r.exp_sse_s = 4000009; r.exp_cnt = 2; r.exp_max = 4000000; r.exp_idx = 5;
        tv[6] = r;

        rst = 1'b1; en = 1'b1; res_ready = 1'b0;
        dut_tdata = '0; ref_tdata = '0; dut_tlast = 1'b0; ref_tlast = 1'b0;
        dut_tvalid = 1'b1; ref_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tready", {62'd0, dut_tready, ref_tready}, 64'd0);
        chk("reset_valid", 64'(res_valid), 64'd0);
        chk("reset_sse", 64'(res_sse), 64'd0);
        chk("reset_err_cnt", 64'(res_err_cnt), 64'd0);
        chk("reset_flags", {62'd0, res_len_err, res_sat}, 64'd0);
        chk("reset_frm_cnt", 64'(frm_cnt), 64'd0);
        rst = 1'b0; en = 1'b0; dut_tvalid = 1'b0; ref_tvalid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            run_frame(tv[i], -1, 0, -1, $sformatf("vec%0d", i));

        run_frame(tv[1], 2, 0, -1, "stall");
        run_frame(tv[6], -1, 10, -1, "hold");

        // Reset in the middle of an errored frame must discard it entirely.
        run_frame(tv[6], -1, 0, 3, "abort");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_frm = 0;
        dut_tvalid = 1'b1; ref_tvalid = 1'b1;
        #1;
        chk("midrst_tready", {62'd0, dut_tready, ref_tready}, 64'd0);
        chk("midrst_valid", 64'(res_valid), 64'd0);
        chk("midrst_sse", 64'(res_sse), 64'd0);
        chk("midrst_err_cnt", 64'(res_err_cnt), 64'd0);
        chk("midrst_frm_cnt", 64'(frm_cnt), 64'd0);
        @(posedge clk); #1;
        chk("midrst_idle_tready", {62'd0, dut_tready, ref_tready}, 64'd0);
        dut_tvalid = 1'b0; ref_tvalid = 1'b0;
        run_frame(tv[0], -1, 0, -1, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
